bck_token_issuer: RTL

- Injects new-read BCK_INI tokens into the backward-extension pipeline ring; it is the transmit end of the token interface that the stage-2 control register consumes.
- Accepts read descriptors from the forward-phase result queue over valid/ready and holds them in a one-entry register.
- Issues a descriptor only into an empty (bubble) ring slot and only while the in-flight budget allows.
- Tracks in-flight reads via finish pulses and raises all_done once the last read has drained.

---
 rtl/bck_token_issuer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bck_token_issuer.sv
// bck_token_issuer: transmit end of the BCK_INI token interface.
// Buffers one read descriptor, injects it as a BCK_INI token into a free
// ring slot while the in-flight budget allows, and tracks reads in flight
// until the batch has drained.
module bck_token_issuer #(
  parameter int unsigned MAX_INFLIGHT   = 16,
  parameter int unsigned READ_NUM_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      slot_free,
  input  logic                      finish_in,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [READ_NUM_WIDTH-1:0] desc_read_num,
  input  logic [6:0]                desc_forward_size_n,
  input  logic [6:0]                desc_new_size,
  input  logic [6:0]                desc_mem_wr_addr,
  input  logic [6:0]                desc_min_intv,
  input  logic [63:0]               desc_primary,
  input  logic                      desc_last,
  output logic [5:0]                status,
  output logic [READ_NUM_WIDTH-1:0] read_num,
  output logic [63:0]               primary,
  output logic [6:0]                forward_size_n,
  output logic [6:0]                new_size,
  output logic [6:0]                new_last_size,
  output logic [6:0]                current_wr_addr,
  output logic [6:0]                current_rd_addr,
  output logic [6:0]                mem_wr_addr,
  output logic [6:0]                backward_i,
  output logic [6:0]                backward_j,
  output logic [6:0]                min_intv,
  output logic [7:0]                output_c,
  output logic                      iteration_boundary,
  output logic                      last_one_read,
  output logic [6:0]                inflight,
  output logic                      all_done,
  output logic                      err_underflow
);

  localparam logic [5:0] ST_BCK_INI = 6'b00_1000;
  localparam logic [5:0] ST_BUBBLE  = 6'b00_0000;
  localparam logic [6:0] MAX_Q      = 7'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // One-entry descriptor hold register
  logic [READ_NUM_WIDTH-1:0] r_h_read_num;
  logic [6:0]                r_h_fsn;
  logic [6:0]                r_h_new_size;
  logic [6:0]                r_h_mem_wr_addr;
  logic [6:0]                r_h_min_intv;
  logic [63:0]               r_h_primary;
  logic                      r_h_last;

  // Registered token fields
  logic [5:0]                r_status;
  logic [READ_NUM_WIDTH-1:0] r_read_num;
  logic [63:0]               r_primary;
  logic [6:0]                r_forward_size_n;
  logic [6:0]                r_new_last_size;
  logic [6:0]                r_current_wr_addr;
  logic [6:0]                r_mem_wr_addr;
  logic [6:0]                r_backward_i;
  logic [6:0]                r_min_intv;
  logic                      r_iteration_boundary;
  logic                      r_last_one_read;

  logic [6:0]                r_inflight;
  logic                      r_err_underflow;

  logic                      w_accept;
  logic                      w_issue;
  logic                      w_zero;
  logic [6:0]                w_fsn_m1;

  // Ready only when the hold register is empty and the batch is still open
  assign desc_ready = !rst && !stall && (r_state == S_IDLE);
  assign w_accept   = desc_valid && desc_ready;
  assign w_fsn_m1   = r_h_fsn - 7'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (!stall) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus issue/consume decisions
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_zero       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (r_h_fsn == 7'd0) begin
            w_zero = 1'b1;
          end else if (slot_free && (r_inflight < MAX_Q)) begin
            w_issue = 1'b1;
          end
        end
        if (w_issue || w_zero) begin
          if (!r_h_last) begin
            w_state_next = S_IDLE;
          end else if (w_zero && (r_inflight == 7'd0)) begin
            // A zero-length final read with nothing in flight has nothing to
            // drain, so the batch closes without a DRAIN cycle.
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!stall && (r_inflight == 7'd0)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture an accepted descriptor into the hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_read_num    <= '0;
      r_h_fsn         <= '0;
      r_h_new_size    <= '0;
      r_h_mem_wr_addr <= '0;
      r_h_min_intv    <= '0;
      r_h_primary     <= '0;
      r_h_last        <= 1'b0;
    end else if (!stall && w_accept) begin
      r_h_read_num    <= desc_read_num;
      r_h_fsn         <= desc_forward_size_n;
      r_h_new_size    <= desc_new_size;
      r_h_mem_wr_addr <= desc_mem_wr_addr;
      r_h_min_intv    <= desc_min_intv;
      r_h_primary     <= desc_primary;
      r_h_last        <= desc_last;
    end
  end

  // Token output register: BCK_INI on issue, all-zero bubble otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status             <= ST_BUBBLE;
      r_read_num           <= '0;
      r_primary            <= '0;
      r_forward_size_n     <= '0;
      r_new_last_size      <= '0;
      r_current_wr_addr    <= '0;
      r_mem_wr_addr        <= '0;
      r_backward_i         <= '0;
      r_min_intv           <= '0;
      r_iteration_boundary <= 1'b0;
      r_last_one_read      <= 1'b0;
    end else if (!stall) begin
      if (w_issue) begin
        r_status             <= ST_BCK_INI;
        r_read_num           <= r_h_read_num;
        r_primary            <= r_h_primary;
        r_forward_size_n     <= r_h_fsn;
        r_new_last_size      <= r_h_new_size;
        r_current_wr_addr    <= w_fsn_m1;
        r_mem_wr_addr        <= r_h_mem_wr_addr;
        r_backward_i         <= w_fsn_m1;
        r_min_intv           <= r_h_min_intv;
        r_iteration_boundary <= (r_h_fsn == 7'd1);
        r_last_one_read      <= r_h_last;
      end else begin
        r_status             <= ST_BUBBLE;
        r_read_num           <= '0;
        r_primary            <= '0;
        r_forward_size_n     <= '0;
        r_new_last_size      <= '0;
        r_current_wr_addr    <= '0;
        r_mem_wr_addr        <= '0;
        r_backward_i         <= '0;
        r_min_intv           <= '0;
        r_iteration_boundary <= 1'b0;
        r_last_one_read      <= 1'b0;
      end
    end
  end

  // In-flight counter and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight      <= '0;
      r_err_underflow <= 1'b0;
    end else if (!stall) begin
      if (w_issue && !finish_in) begin
        r_inflight <= r_inflight + 7'd1;
      end else if (finish_in && !w_issue) begin
        if (r_inflight == 7'd0) begin
          r_err_underflow <= 1'b1;
        end else begin
          r_inflight <= r_inflight - 7'd1;
        end
      end
    end
  end

  assign status             = r_status;
  assign read_num           = r_read_num;
  assign primary            = r_primary;
  assign forward_size_n     = r_forward_size_n;
  assign new_size           = '0;
  assign new_last_size      = r_new_last_size;
  assign current_wr_addr    = r_current_wr_addr;
  assign current_rd_addr    = '0;
  assign mem_wr_addr        = r_mem_wr_addr;
  assign backward_i         = r_backward_i;
  assign backward_j         = '0;
  assign min_intv           = r_min_intv;
  assign output_c           = '0;
  assign iteration_boundary = r_iteration_boundary;
  assign last_one_read      = r_last_one_read;
  assign inflight           = r_inflight;
  assign all_done           = (r_state == S_DONE);
  assign err_underflow      = r_err_underflow;

endmodule
